// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// controller states and the default memory size.
package dm_access_pkg;

    localparam int unsigned DATA_MEM_SIZE_DEF = 128;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDDATA,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// CPU-side request/response channel of the data-memory access controller.
interface dm_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              req_ready;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  req_ready, rdata, done, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output req_ready, rdata, done, err
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Big-endian lane steering: extracts/extends a load lane from a memory word
// and merges store data into the addressed lane of a read word.
module dm_byte_lane
    import dm_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = '0;
        lane_h     = offset[1] ? word[15:0] : word[31:16];
        load_data  = word;
        store_data = word;
        case (offset)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        case (size_e'(size))
            SZ_BYTE: begin
                load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
                case (offset)
                    2'd0:    store_data[31:24] = wdata[7:0];
                    2'd1:    store_data[23:16] = wdata[7:0];
                    2'd2:    store_data[15:8]  = wdata[7:0];
                    default: store_data[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
                if (offset[1]) store_data[15:0]  = wdata[15:0];
                else           store_data[31:16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_data = wdata;
            end
        endcase
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store initiator for a word-wide big-endian data memory; sub-word
// stores are done as read-modify-write. All outputs are registered.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int unsigned DATA_MEM_SIZE = DATA_MEM_SIZE_DEF,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       MemReadData
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_MEM_SIZE - 1);

    state_e            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, sign_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_n;
    logic              done_q, done_n, err_q, err_n, ready_q, ready_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wdata_n;
    logic              mem_rd_n, mem_wr_n;
    logic              accept, req_err;
    logic [31:0]       load_data, store_data;

    assign accept        = bus.req & ready_q;
    assign bus.req_ready = ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_comb begin
        req_err = 1'b0;
        case (size_e'(bus.size))
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.addr[0];
            SZ_WORD: req_err = |bus.addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (bus.addr > LAST_ADDR) req_err = 1'b1;
    end

    dm_byte_lane u_lane (
        .word       (MemReadData),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sign_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            MemAddr      <= '0;
            MemWriteData <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state        <= state_n;
            ready_q      <= ready_n;
            done_q       <= done_n;
            err_q        <= err_n;
            rdata_q      <= rdata_n;
            MemAddr      <= mem_addr_n;
            MemWriteData <= mem_wdata_n;
            MemRead      <= mem_rd_n;
            MemWrite     <= mem_wr_n;
            if (accept) begin
                addr_q  <= bus.addr;
                we_q    <= bus.we;
                size_q  <= bus.size;
                sign_q  <= bus.sign_ext;
                wdata_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                  state_n = DONE;
                    else if (bus.we && size_e'(bus.size) == SZ_WORD) state_n = WR;
                    else                                          state_n = RD;
                end
            end
            RD:      state_n = RDDATA;
            RDDATA:  state_n = we_q ? WR : DONE;
            WR:      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed as next values so every port comes straight from a flop.
    always_comb begin
        mem_addr_n  = MemAddr;
        mem_wdata_n = MemWriteData;
        rdata_n     = rdata_q;
        mem_rd_n    = 1'b0;
        mem_wr_n    = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        ready_n     = (state_n == IDLE);
        if (accept && !req_err) begin
            mem_addr_n = {bus.addr[ADDR_W-1:2], 2'b00};
            if (bus.we) mem_wdata_n = bus.wdata;
        end
        if (state == RDDATA) begin
            if (we_q) mem_wdata_n = store_data;
            else      rdata_n     = load_data;
        end
        case (state_n)
            RD:   mem_rd_n = 1'b1;
            WR:   mem_wr_n = 1'b1;
            DONE: begin
                done_n = 1'b1;
                err_n  = (state == IDLE) && req_err;
            end
            default: ;
        endcase
    end
endmodule
